// File: rtl/prio_pkg.sv
// Shared types and helpers for the round-robin/fixed priority arbiter.
package prio_pkg;

   typedef enum logic {IDLE, HOLD} arb_state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width that never collapses to zero bits for tiny N.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_enc_msb.sv
// MSB-first priority encoder with optional rotation so the search starts at ptr.
module prio_enc_msb
   import prio_pkg::*;
#(
   parameter  int N    = 8,
   localparam int IDXW = clog2_min1(N)
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   input  logic            rr,
   output logic [IDXW-1:0] idx,
   output logic            any
);

   logic [N-1:0]    rot;
   logic [N-1:0]    src;
   logic [IDXW-1:0] shamt;
   logic [IDXW-1:0] enc;
   logic [IDXW:0]   sum;

   // Rotating left by N-1-ptr puts source ptr at the top so a plain MSB search
   // yields the round-robin order; the found index is then mapped back mod N.
   always_comb begin
      shamt = IDXW'(N - 1) - ptr;
      rot   = '0;
      for (int k = 0; k < N; k++) begin
         int j;
         j = k - int'(shamt);
         if (j < 0) j = j + N;
         rot[k] = req[j];
      end
      src = rr ? rot : req;
      enc = '0;
      for (int k = 0; k < N; k++) begin
         if (src[k]) enc = IDXW'(k);
      end
      sum = {1'b0, enc} + {1'b0, ptr} + (IDXW+1)'(1);
      if (!rr)
         idx = enc;
      else if (sum >= (IDXW+1)'(N))
         idx = IDXW'(sum - (IDXW+1)'(N));
      else
         idx = sum[IDXW-1:0];
   end

   assign any = |req;

endmodule

// File: rtl/prio_arb_rr.sv
// N-input arbiter with fixed or round-robin priority and a sticky, handshaked grant.
//
//  state | meaning
//  IDLE  | no grant held, outputs zero, waiting for any request
//  HOLD  | grant registered and presented until out_ready_i accepts it
module prio_arb_rr
   import prio_pkg::*;
#(
   parameter  int N    = 8,
   localparam int IDXW = clog2_min1(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req_i,
   input  logic            mode_rr_i,
   output logic            out_valid_o,
   output logic [IDXW-1:0] out_idx_o,
   output logic [N-1:0]    out_oh_o,
   input  logic            out_ready_i
);

   arb_state_t      state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [N-1:0]    oh_q, oh_d;
   logic            mode_q, mode_d;
   logic            load;
   logic [IDXW-1:0] win_idx;
   logic            win_any;

   // The encoder sees the already-updated pointer so a just-granted source
   // drops to lowest priority on a back-to-back grant.
   prio_enc_msb #(.N(N)) u_enc (
      .req (req_i),
      .ptr (ptr_d),
      .rr  (mode_rr_i == MODE_RR),
      .idx (win_idx),
      .any (win_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDXW'(N - 1);
         idx_q   <= '0;
         oh_q    <= '0;
         mode_q  <= MODE_FIXED;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      mode_d  = mode_q;
      load    = 1'b0;
      case (state_q)
         IDLE: load = 1'b1;
         HOLD: begin
            if (out_ready_i) begin
               // Pointer moves according to the mode the held grant was won under.
               if (mode_q == MODE_RR)
                  ptr_d = (idx_q == '0) ? IDXW'(N - 1) : idx_q - IDXW'(1);
               load = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         if (win_any) begin
            state_d = HOLD;
            idx_d   = win_idx;
            oh_d    = N'(1) << win_idx;
            mode_d  = mode_rr_i;
         end else begin
            state_d = IDLE;
            idx_d   = '0;
            oh_d    = '0;
         end
      end
   end

   assign out_valid_o = (state_q == HOLD);
   assign out_idx_o   = idx_q;
   assign out_oh_o    = oh_q;

endmodule
